// File: rtl/postfix_term_loader_if.sv
// postfix_term_loader_if: code stream, memory write port and load status of the
// postfix term loader. slave = loader side, master = producer / memory side.
interface postfix_term_loader_if #(
    parameter int CODE_WIDTH         = 8,
    parameter int POSTFIX_DATA_WIDTH = 9,
    parameter int ADDR_WIDTH         = 10
);
    logic                          load_start;
    logic                          code_valid;
    logic [CODE_WIDTH-1:0]         code_in;
    logic                          code_last;
    logic                          code_ready;
    logic [ADDR_WIDTH-1:0]         mem_term_detail_postfix_addr;
    logic [POSTFIX_DATA_WIDTH-1:0] mem_term_detail_postfix_data_in;
    logic                          mem_term_detail_postfix_wr_en;
    logic [ADDR_WIDTH:0]           term_length;
    logic                          load_done;
    logic                          load_error;
    logic [1:0]                    error_code;

    modport slave (
        input  load_start, code_valid, code_in, code_last,
        output code_ready, mem_term_detail_postfix_addr, mem_term_detail_postfix_data_in,
               mem_term_detail_postfix_wr_en, term_length, load_done, load_error, error_code
    );

    modport master (
        output load_start, code_valid, code_in, code_last,
        input  code_ready, mem_term_detail_postfix_addr, mem_term_detail_postfix_data_in,
               mem_term_detail_postfix_wr_en, term_length, load_done, load_error, error_code
    );
endinterface

// File: rtl/postfix_term_loader.sv
// postfix_term_loader: writes one postfix term from a valid/ready code stream into
// the term memory starting at address 0, then appends the END word.
// Optional build macro POSTFIX_LOADER_DEPTH_CHECK_EN adds operand stack depth tracking
// (error 10); without it only illegal-code (01) and capacity (11) errors exist.
//
// state       | meaning
// S_IDLE      | waiting for load_start, stream stalled
// S_ACCEPT    | taking codes; each accepted code is written on the following cycle
// S_WRITE_END | last code being written, END word queued behind it
// S_DONE      | END word written, load_done pulse, term_length valid
// S_ERROR     | load aborted, error held until load_start
module postfix_term_loader #(
    parameter int CODE_WIDTH         = 8,
    parameter int POSTFIX_DATA_WIDTH = 9,
    parameter int POSTFIX_DATA_DEPTH = 1024,
    parameter int MAX_STACK_DEPTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    postfix_term_loader_if.slave io_ldr
);
    localparam int AW = $clog2(POSTFIX_DATA_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    // A non-last code at this address would leave no room for END behind its successor.
    localparam logic [AW:0] CAP_LIMIT = (AW+1)'(POSTFIX_DATA_DEPTH - 2);
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_STACK    = 2'b10;
    localparam logic [1:0] ERR_CAPACITY = 2'b11;
    localparam logic [POSTFIX_DATA_WIDTH-1:0] END_WORD = {1'b1, {CODE_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE_END,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [AW:0]                   r_cnt;
    logic [AW:0]                   w_cnt_d;
    logic [1:0]                    r_err_code;
    logic [1:0]                    w_err_d;
    logic [AW:0]                   r_term_len;
    logic [AW:0]                   w_len_d;
    logic                          r_wr_en;
    logic                          w_wr_en_d;
    logic [AW-1:0]                 r_wr_addr;
    logic [AW-1:0]                 w_wr_addr_d;
    logic [POSTFIX_DATA_WIDTH-1:0] r_wr_data;
    logic [POSTFIX_DATA_WIDTH-1:0] w_wr_data_d;

    logic [1:0] w_class;
    logic [2:0] w_op;
    logic       w_is_op;
    logic       w_illegal;
    logic       w_accept;
    logic       w_cap_fail;
    logic       w_stack_fail;

    assign w_class    = io_ldr.code_in[CODE_WIDTH-1 -: 2];
    assign w_op       = io_ldr.code_in[2:0];
    assign w_is_op    = (w_class == 2'b10);
    assign w_illegal  = (io_ldr.code_in == {CODE_WIDTH{1'b1}}) || (w_is_op && (w_op > 3'd4));
    assign w_accept   = io_ldr.code_valid && (r_state == S_ACCEPT);
    assign w_cap_fail = !io_ldr.code_last && (r_cnt == CAP_LIMIT);

`ifdef POSTFIX_LOADER_DEPTH_CHECK_EN
    localparam int DPW = $clog2(MAX_STACK_DEPTH + 1);
    localparam logic [DPW-1:0] DEPTH_MAX = DPW'(MAX_STACK_DEPTH);
    localparam logic [DPW-1:0] DEPTH_ONE = DPW'(1);
    localparam logic [DPW-1:0] DEPTH_TWO = DPW'(2);

    logic [DPW-1:0] r_depth;
    logic [DPW-1:0] w_depth_upd;
    logic           w_restart;
    logic           w_commit;

    assign w_restart = ((r_state == S_IDLE) || (r_state == S_ERROR)) && io_ldr.load_start;
    assign w_commit  = w_accept && !w_illegal && !w_cap_fail && !w_stack_fail;

    // Operand stack model: operands push, operators pop two and push one.
    always_comb begin
        w_stack_fail = 1'b0;
        w_depth_upd  = r_depth;
        if (w_is_op) begin
            if (r_depth < DEPTH_TWO) w_stack_fail = 1'b1;
            else                     w_depth_upd  = r_depth - DEPTH_ONE;
        end else begin
            if (r_depth == DEPTH_MAX) w_stack_fail = 1'b1;
            else                      w_depth_upd  = r_depth + DEPTH_ONE;
        end
        if (!w_stack_fail && io_ldr.code_last && (w_depth_upd != DEPTH_ONE))
            w_stack_fail = 1'b1;
    end

    // Depth counter restarts with each load and follows committed codes only.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)       r_depth <= '0;
        else if (w_restart) r_depth <= '0;
        else if (w_commit)  r_depth <= w_depth_upd;
    end
`else
    assign w_stack_fail = 1'b0;
`endif

    // Next state, checks on the accepting cycle, and the write queued for next cycle.
    always_comb begin
        w_next_state = r_state;
        w_cnt_d      = r_cnt;
        w_err_d      = r_err_code;
        w_len_d      = r_term_len;
        w_wr_en_d    = 1'b0;
        w_wr_addr_d  = '0;
        w_wr_data_d  = '0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (io_ldr.load_start) begin
                    w_next_state = S_ACCEPT;
                    w_cnt_d      = '0;
                    w_err_d      = ERR_NONE;
                    w_len_d      = '0;
                end
            end
            S_ACCEPT: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_err_d      = ERR_ILLEGAL;
                        w_next_state = S_ERROR;
                    end else if (w_cap_fail) begin
                        w_err_d      = ERR_CAPACITY;
                        w_next_state = S_ERROR;
                    end else if (w_stack_fail) begin
                        w_err_d      = ERR_STACK;
                        w_next_state = S_ERROR;
                    end else begin
                        w_wr_en_d   = 1'b1;
                        w_wr_addr_d = r_cnt[AW-1:0];
                        w_wr_data_d = {1'b0, io_ldr.code_in};
                        w_cnt_d     = r_cnt + CNT_ONE;
                        if (io_ldr.code_last) w_next_state = S_WRITE_END;
                    end
                end
            end
            S_WRITE_END: begin
                w_wr_en_d    = 1'b1;
                w_wr_addr_d  = r_cnt[AW-1:0];
                w_wr_data_d  = END_WORD;
                w_cnt_d      = r_cnt + CNT_ONE;
                w_len_d      = r_cnt + CNT_ONE;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Address counter, error code, term length and the registered write port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_err_code <= ERR_NONE;
            r_term_len <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_cnt      <= w_cnt_d;
            r_err_code <= w_err_d;
            r_term_len <= w_len_d;
            r_wr_en    <= w_wr_en_d;
            r_wr_addr  <= w_wr_addr_d;
            r_wr_data  <= w_wr_data_d;
        end
    end

    assign io_ldr.code_ready                      = (r_state == S_ACCEPT);
    assign io_ldr.mem_term_detail_postfix_wr_en   = r_wr_en;
    assign io_ldr.mem_term_detail_postfix_addr    = r_wr_addr;
    assign io_ldr.mem_term_detail_postfix_data_in = r_wr_data;
    assign io_ldr.term_length                     = r_term_len;
    assign io_ldr.load_done                       = (r_state == S_DONE);
    assign io_ldr.load_error                      = (r_state == S_ERROR);
    assign io_ldr.error_code                      = r_err_code;
endmodule

// File: tb/tb_postfix_term_loader.sv
// tb_postfix_term_loader: directed tests for postfix_term_loader (default or
// POSTFIX_LOADER_DEPTH_CHECK_EN build).
module tb_postfix_term_loader;
    localparam int CW    = 8;
    localparam int DW    = 9;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int MSD   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    postfix_term_loader_if #(.CODE_WIDTH(CW), .POSTFIX_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    postfix_term_loader #(
        .CODE_WIDTH(CW), .POSTFIX_DATA_WIDTH(DW),
        .POSTFIX_DATA_DEPTH(DEPTH), .MAX_STACK_DEPTH(MSD)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_ldr (bus)
    );

    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];

    always @(negedge clk) begin
        if (bus.mem_term_detail_postfix_wr_en === 1'b1) begin
            log_addr.push_back(bus.mem_term_detail_postfix_addr);
            log_data.push_back(bus.mem_term_detail_postfix_data_in);
        end
    end

    // Number of differences between the writes logged since base and exp_addr/exp_data.
    function automatic int log_diffs(input int base);
        int d = 0;
        if (log_addr.size() - base != exp_addr.size()) d++;
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (base + i >= log_addr.size()) d++;
            else if (log_addr[base+i] !== exp_addr[i] || log_data[base+i] !== exp_data[i]) d++;
        end
        return d;
    endfunction

    function automatic logic [7:0] cap_code(input int k);
        logic [7:0] c;
        if (k == 0 || (k % 2) == 1) c = 8'h40 | 8'(k % 64);
        else                        c = 8'h82;
        return c;
    endfunction

    task automatic do_reset();
        bus.load_start = 1'b0;
        bus.code_valid = 1'b0;
        bus.code_in    = '0;
        bus.code_last  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
    endtask

    task automatic send_code(input logic [7:0] c, input logic last, input int gap, output logic ok);
        logic rdy;
        ok = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.code_valid = 1'b1;
        bus.code_in    = c;
        bus.code_last  = last;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rdy = bus.code_ready;
            @(posedge clk); #1;
            if (rdy === 1'b1) begin ok = 1'b1; break; end
        end
        bus.code_valid = 1'b0;
        bus.code_in    = '0;
        bus.code_last  = 1'b0;
    endtask

    task automatic wait_done(output logic ok, output logic [AW:0] len);
        ok  = 1'b0;
        len = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.load_done === 1'b1) begin ok = 1'b1; len = bus.term_length; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic push_case1();
        exp_addr = {};
        exp_data = {};
        exp_addr.push_back(10'd0); exp_data.push_back(9'h000);
        exp_addr.push_back(10'd1); exp_data.push_back(9'h001);
        exp_addr.push_back(10'd2); exp_data.push_back(9'h082);
        exp_addr.push_back(10'd3); exp_data.push_back(9'h1FF);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if (bus.code_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_code_ready: got %b want 0", bus.code_ready);
        end
        n_tests++;
        if (bus.mem_term_detail_postfix_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_term_detail_postfix_wr_en);
        end
        n_tests++;
        if ({bus.mem_term_detail_postfix_addr, bus.mem_term_detail_postfix_data_in, bus.term_length} !== '0) begin
            n_fail++; $display("FAIL reset_addr_data_len: got %h/%h/%h want 0/0/0", bus.mem_term_detail_postfix_addr,
                               bus.mem_term_detail_postfix_data_in, bus.term_length);
        end
        n_tests++;
        if ({bus.load_done, bus.load_error, bus.error_code} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_status: got done=%b err=%b code=%b want 0/0/00",
                               bus.load_done, bus.load_error, bus.error_code);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic ok;
        int   base;
        do_reset();
        base = log_addr.size();
        start_load();
        send_code(8'h00, 1'b0, 0, ok);
        send_code(8'h01, 1'b0, 0, ok);
        send_code(8'h82, 1'b1, 0, ok);
        @(negedge clk);
        n_tests++;
        if ({bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr, bus.mem_term_detail_postfix_data_in}
            !== {1'b1, 10'd2, 9'h082}) begin
            n_fail++; $display("FAIL basic_last_code_write: got en=%b addr=%0d data=%h want 1/2/082",
                               bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr,
                               bus.mem_term_detail_postfix_data_in);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr, bus.mem_term_detail_postfix_data_in,
             bus.load_done, bus.term_length} !== {1'b1, 10'd3, 9'h1FF, 1'b1, 11'd4}) begin
            n_fail++; $display("FAIL basic_end_write: got en=%b addr=%0d data=%h done=%b len=%0d want 1/3/1FF/1/4",
                               bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr,
                               bus.mem_term_detail_postfix_data_in, bus.load_done, bus.term_length);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.load_done, bus.mem_term_detail_postfix_wr_en, bus.code_ready} !== 3'b000) begin
            n_fail++; $display("FAIL basic_after_done: got done=%b en=%b rdy=%b want 0/0/0",
                               bus.load_done, bus.mem_term_detail_postfix_wr_en, bus.code_ready);
        end
        @(posedge clk); #1;
        push_case1();
        n_tests++;
        if (log_diffs(base) != 0) begin
            n_fail++; $display("FAIL basic_image: got %0d write differences want 0", log_diffs(base));
        end
    endtask

    task automatic test_illegal();
        logic ok;
        int   base;
        do_reset();
        base = log_addr.size();
        start_load();
        send_code(8'hFF, 1'b0, 0, ok);
        @(negedge clk);
        n_tests++;
        if ({bus.load_error, bus.error_code, bus.code_ready, bus.mem_term_detail_postfix_wr_en} !== 5'b10100) begin
            n_fail++; $display("FAIL illegal_ff: got err=%b code=%b rdy=%b en=%b want 1/01/0/0",
                               bus.load_error, bus.error_code, bus.code_ready, bus.mem_term_detail_postfix_wr_en);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.load_error, bus.error_code} !== 3'b101 || log_addr.size() != base) begin
            n_fail++; $display("FAIL illegal_held: got err=%b code=%b writes=%0d want 1/01/0",
                               bus.load_error, bus.error_code, log_addr.size() - base);
        end
        @(posedge clk); #1;
        start_load();
        @(negedge clk);
        n_tests++;
        if ({bus.load_error, bus.error_code, bus.code_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL illegal_restart: got err=%b code=%b rdy=%b want 0/00/1",
                               bus.load_error, bus.error_code, bus.code_ready);
        end
        @(posedge clk); #1;
        send_code(8'h85, 1'b0, 0, ok);
        @(negedge clk);
        n_tests++;
        if ({bus.load_error, bus.error_code, bus.mem_term_detail_postfix_wr_en} !== 4'b1010 || log_addr.size() != base) begin
            n_fail++; $display("FAIL illegal_op101: got err=%b code=%b en=%b writes=%0d want 1/01/0/0",
                               bus.load_error, bus.error_code, bus.mem_term_detail_postfix_wr_en, log_addr.size() - base);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_operator_first();
        logic          ok;
        logic [AW:0]   len;
        int            base;
        do_reset();
        base = log_addr.size();
        start_load();
        send_code(8'h83, 1'b0, 0, ok);
        @(negedge clk);
`ifdef POSTFIX_LOADER_DEPTH_CHECK_EN
        n_tests++;
        if ({bus.load_error, bus.error_code, bus.mem_term_detail_postfix_wr_en} !== 4'b1100 || log_addr.size() != base) begin
            n_fail++; $display("FAIL opfirst_stack: got err=%b code=%b en=%b writes=%0d want 1/10/0/0",
                               bus.load_error, bus.error_code, bus.mem_term_detail_postfix_wr_en, log_addr.size() - base);
        end
        @(posedge clk); #1;
        do_reset();
        base = log_addr.size();
        start_load();
        send_code(8'h00, 1'b0, 0, ok);
        send_code(8'h01, 1'b1, 0, ok);
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.load_error, bus.error_code} !== 3'b110 || log_addr.size() != base + 1) begin
            n_fail++; $display("FAIL last_depth_two: got err=%b code=%b writes=%0d want 1/10/1",
                               bus.load_error, bus.error_code, log_addr.size() - base);
        end
        @(posedge clk); #1;
        len = '0;
`else
        n_tests++;
        if ({bus.load_error, bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr,
             bus.mem_term_detail_postfix_data_in} !== {1'b0, 1'b1, 10'd0, 9'h083}) begin
            n_fail++; $display("FAIL opfirst_written: got err=%b en=%b addr=%0d data=%h want 0/1/0/083",
                               bus.load_error, bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr,
                               bus.mem_term_detail_postfix_data_in);
        end
        @(posedge clk); #1;
        send_code(8'h00, 1'b1, 0, ok);
        wait_done(ok, len);
        n_tests++;
        if (ok !== 1'b1 || len !== 11'd3) begin
            n_fail++; $display("FAIL opfirst_done: got seen=%b len=%0d want 1/3", ok, len);
        end
`endif
    endtask

    task automatic test_capacity();
        logic        ok;
        logic [AW:0] len;
        int          base;
        int          c0;
        do_reset();
        base = log_addr.size();
        start_load();
        c0 = cyc;
        exp_addr = {};
        exp_data = {};
        for (int k = 0; k < DEPTH - 1; k++) begin
            send_code(cap_code(k), (k == DEPTH - 2), 0, ok);
            exp_addr.push_back(AW'(k));
            exp_data.push_back({1'b0, cap_code(k)});
        end
        exp_addr.push_back(AW'(DEPTH - 1));
        exp_data.push_back(9'h1FF);
        n_tests++;
        if (cyc - c0 != DEPTH - 1) begin
            n_fail++; $display("FAIL cap_throughput: got %0d cycles for %0d codes want %0d", cyc - c0, DEPTH - 1, DEPTH - 1);
        end
        wait_done(ok, len);
        n_tests++;
        if (ok !== 1'b1 || len !== 11'd1024) begin
            n_fail++; $display("FAIL cap_full_len: got seen=%b len=%0d want 1/1024", ok, len);
        end
        n_tests++;
        if (log_diffs(base) != 0) begin
            n_fail++; $display("FAIL cap_full_image: got %0d write differences want 0", log_diffs(base));
        end

        do_reset();
        base = log_addr.size();
        start_load();
        for (int k = 0; k < DEPTH - 2; k++) send_code(cap_code(k), 1'b0, 0, ok);
        send_code(cap_code(DEPTH - 2), 1'b0, 0, ok);
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.load_error, bus.error_code} !== 3'b111 || log_addr.size() != base + DEPTH - 2) begin
            n_fail++; $display("FAIL cap_overflow: got err=%b code=%b writes=%0d want 1/11/%0d",
                               bus.load_error, bus.error_code, log_addr.size() - base, DEPTH - 2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        logic        ok;
        logic [AW:0] len;
        int          base;
        for (int it = 0; it < 2; it++) begin
            do_reset();
            base = log_addr.size();
            start_load();
            send_code(8'h00, 1'b0, int'($urandom_range(3, 0)), ok);
            send_code(8'h01, 1'b0, int'($urandom_range(3, 1)), ok);
            send_code(8'h82, 1'b1, int'($urandom_range(3, 1)), ok);
            wait_done(ok, len);
            repeat (2) @(posedge clk); #1;
            n_tests++;
            if (ok !== 1'b1 || len !== 11'd4) begin
                n_fail++; $display("FAIL gaps_done_%0d: got seen=%b len=%0d want 1/4", it, ok, len);
            end
            push_case1();
            n_tests++;
            if (log_diffs(base) != 0) begin
                n_fail++; $display("FAIL gaps_image_%0d: got %0d write differences want 0", it, log_diffs(base));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic        ok;
        logic [AW:0] len;
        int          base;
        do_reset();
        base = log_addr.size();
        start_load();
        send_code(8'h00, 1'b0, 0, ok);
        send_code(8'h01, 1'b0, 0, ok);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({bus.code_ready, bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr,
             bus.mem_term_detail_postfix_data_in, bus.term_length, bus.load_done, bus.load_error, bus.error_code} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got rdy=%b en=%b addr=%0d data=%h len=%0d done=%b err=%b code=%b want all 0",
                               bus.code_ready, bus.mem_term_detail_postfix_wr_en, bus.mem_term_detail_postfix_addr,
                               bus.mem_term_detail_postfix_data_in, bus.term_length, bus.load_done, bus.load_error,
                               bus.error_code);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_load();
        send_code(8'h05, 1'b1, 0, ok);
        wait_done(ok, len);
        n_tests++;
        if (ok !== 1'b1 || len !== 11'd2) begin
            n_fail++; $display("FAIL midreset_reload_len: got seen=%b len=%0d want 1/2", ok, len);
        end
        exp_addr = {};
        exp_data = {};
        exp_addr.push_back(10'd0); exp_data.push_back(9'h000);
        exp_addr.push_back(10'd1); exp_data.push_back(9'h001);
        exp_addr.push_back(10'd0); exp_data.push_back(9'h005);
        exp_addr.push_back(10'd1); exp_data.push_back(9'h1FF);
        n_tests++;
        if (log_diffs(base) != 0) begin
            n_fail++; $display("FAIL midreset_image: got %0d write differences want 0", log_diffs(base));
        end
    endtask

    task automatic test_start_ignored();
        logic ok;
        int   base;
        do_reset();
        base = log_addr.size();
        start_load();
        send_code(8'h00, 1'b0, 0, ok);
        bus.load_start = 1'b1;
        send_code(8'h01, 1'b0, 0, ok);
        bus.load_start = 1'b0;
        send_code(8'h82, 1'b1, 0, ok);
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({bus.load_done, bus.term_length, bus.load_error} !== {1'b1, 11'd4, 1'b0}) begin
            n_fail++; $display("FAIL start_ign_done: got done=%b len=%0d err=%b want 1/4/0",
                               bus.load_done, bus.term_length, bus.load_error);
        end
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.code_ready, bus.load_done} !== 2'b00) begin
            n_fail++; $display("FAIL start_ign_idle: got rdy=%b done=%b want 0/0", bus.code_ready, bus.load_done);
        end
        @(posedge clk); #1;
        push_case1();
        n_tests++;
        if (log_diffs(base) != 0) begin
            n_fail++; $display("FAIL start_ign_image: got %0d write differences want 0", log_diffs(base));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_operator_first();
        test_capacity();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
